aes_key_sched_ctrl: RTL

Sequential AES key-schedule controller. It accepts a cipher key over a valid/ready handshake and expands it one 32-bit word per clock into an internal round-key store. It then serves 128-bit round keys by round index to the cipher round datapath. It replaces the fully combinational expansion wherever area matters more than key-load latency: one shared 4-byte S-box path instead of one per word.

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/aes_key_sched_ctrl_subword.sv | 13 +
 rtl/aes_key_sched_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the sequential AES key-schedule controller:
// S-box table, GF(2^8) doubling, word rotation, word-count constant and
// the controller state encoding.
package aes_pkg;

  localparam int NB_AES     = 4;
  localparam int NR_DEFAULT = 10;
  localparam int NW         = NB_AES * (NR_DEFAULT + 1);

  // Word count of a schedule for an arbitrary round count.
  function automatic int nw_of(input int nr);
    return NB_AES * (nr + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  // Forward S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] a);
    return {a[23:0], a[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_subword.sv
// aes_subword: combinational S-box substitution of all four bytes of a word.
// A single instance is shared by the rotated (k==0) and plain (k==4) cases.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl: accepts a cipher key over valid/ready, expands it one
// 32-bit word per clock through a single shared SubWord path, then serves
// 128-bit round keys by round index with one cycle of read latency.
// Optional macro AES_KEYSCHED_DEC_ORDER_EN adds rd_dec, which reverses the
// round index (NR - rd_round) for a decryption core counting upward.
//
// state     | meaning
// ST_IDLE   | no schedule held, waiting for a key
// ST_EXPAND | generating w[i], one word per cycle
// ST_READY  | full schedule stored, reads served, new key accepted
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10,
  parameter int NB = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [32*NK-1:0] key,
  output logic            busy,
  output logic            keys_valid,
  input  logic            rd_en,
  input  logic [3:0]      rd_round,
`ifdef AES_KEYSCHED_DEC_ORDER_EN
  input  logic            rd_dec,
`endif
  output logic            rd_valid,
  output logic [127:0]    rd_key
);

  localparam int NWORDS = NB * (NR + 1);
  localparam int IW     = $clog2(NWORDS + 1);

  // Round-key store; deliberately left out of reset.
  logic [31:0]   r_w [NWORDS];

  ks_state_t     r_state;
  logic [IW-1:0] r_i;
  logic [2:0]    r_k;
  logic [7:0]    r_rcon;
  logic          r_key_ready;
  logic          r_busy;
  logic          r_keys_valid;
  logic          r_rd_valid;
  logic [127:0]  r_rd_key;

  logic          w_load;
  logic [31:0]   w_prev;
  logic [31:0]   w_back;
  logic [31:0]   w_sub_in;
  logic [31:0]   w_sub_out;
  logic [31:0]   w_temp;
  logic [31:0]   w_new;
  logic [3:0]    w_eff;
  logic [IW-1:0] w_base;
  logic          w_rd_oob;
  logic          w_rd_take;

  // key_ready is only high in IDLE/READY, so this is the accepted handshake.
  assign w_load = key_valid & r_key_ready & ~rst;

  assign w_prev   = r_w[r_i - IW'(1)];
  assign w_back   = r_w[r_i - IW'(NK)];
  assign w_sub_in = (r_k == 3'd0) ? rot_word(w_prev) : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  // Select the temp word: rotated+substituted with rcon, substituted only, or raw.
  always_comb begin
    w_temp = w_prev;
    if (r_k == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h000000};
    end else if (NK > 6 && r_k == 3'd4) begin
      w_temp = w_sub_out;
    end
  end

  assign w_new = w_back ^ w_temp;

  // Store update: key words on handshake, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int j = 0; j < NK; j++) begin
        r_w[j] <= key[32*(NK-j)-1 -: 32];
      end
    end else if (!rst && r_state == ST_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_i          <= '0;
      r_k          <= '0;
      r_rcon       <= 8'h01;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_READY: begin
          if (key_valid) begin
            r_state      <= ST_EXPAND;
            r_i          <= IW'(NK);
            r_k          <= '0;
            r_rcon       <= 8'h01;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_keys_valid <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (r_k == 3'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          r_k <= (r_k == 3'(NK - 1)) ? 3'd0 : r_k + 3'd1;
          r_i <= r_i + IW'(1);
          if (r_i == IW'(NWORDS - 1)) begin
            r_state      <= ST_READY;
            r_busy       <= 1'b0;
            r_keys_valid <= 1'b1;
            r_key_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_key_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_keys_valid <= 1'b0;
        end
      endcase
    end
  end

  // Effective round index, optionally reversed for decryption order.
  always_comb begin
    w_eff = rd_round;
`ifdef AES_KEYSCHED_DEC_ORDER_EN
    if (rd_dec && rd_round <= 4'(NR)) begin
      w_eff = 4'(NR) - rd_round;
    end
`endif
  end

  assign w_base    = IW'({w_eff, 2'b00});
  assign w_rd_oob  = (rd_round > 4'(NR));
  assign w_rd_take = rd_en & r_keys_valid;

  // Registered read port; requests without a valid schedule are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_key   <= '0;
    end else begin
      r_rd_valid <= w_rd_take;
      if (w_rd_take) begin
        r_rd_key <= w_rd_oob ? 128'h0 :
                    {r_w[w_base], r_w[w_base + IW'(1)],
                     r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]};
      end
    end
  end

  assign key_ready  = r_key_ready;
  assign busy       = r_busy;
  assign keys_valid = r_keys_valid;
  assign rd_valid   = r_rd_valid;
  assign rd_key     = r_rd_key;

endmodule
